control_sequencer: RTL and testbench
====================================

# control_sequencer

Moore-style control sequencer for the 8-bit bus computer: it steps a T-state counter through fetch and execute phases and drives every load/output-enable strobe on the shared bus, including the program counter's `step`, `oe` and `ie` inputs. It sits between the instruction register, which supplies the opcode, and all bus-attached registers. State advances on the rising edge, so strobes are stable when the datapath registers act on the falling edge.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock; sequencer state changes on posedge only.
- `rst`  in  1  asynchronous, active-low reset (`rst` = 0 resets the block).
- `opcode`  in  4  instruction register bits [7:4]; sampled combinationally in T2–T4.
- `pc_step`, `pc_oe`, `pc_ie`  out  1 each  program counter increment, bus drive and bus load.
- `mar_ie`  out  1  memory address register load.
- `ram_oe`  out  1  RAM bus drive.
- `ir_ie`, `ir_oe`  out  1 each  instruction register load, and operand (low nibble, zero-extended) bus drive.
- `a_ie`, `a_oe`, `b_ie`  out  1 each  A register load and drive; B register load.
- `alu_oe`, `alu_sub`  out  1 each  ALU bus drive; subtract select.
- `out_ie`  out  1  output register load.
- `halt`  out  1  high once HLT has executed.
- `tstate`  out  3  current T-state, 0–4; reads 0 while halted.

## Operation
- States: T0–T4, plus HALT. All outputs decode from the current state and `opcode` only. No output is registered.
- Fetch, identical for all opcodes:
  - T0: `pc_oe`, `mar_ie`.
  - T1: `ram_oe`, `ir_ie`, `pc_step`.
- Execute, by opcode:
  - 0000 LDA: T2 `ir_oe`,`mar_ie`; T3 `ram_oe`,`a_ie`; then T0.
  - 0001 ADD: T2 `ir_oe`,`mar_ie`; T3 `ram_oe`,`b_ie`; T4 `alu_oe`,`a_ie`; then T0.
  - 0010 SUB: same as ADD, with `alu_sub` high in T3 and T4.
  - 1110 OUT: T2 `a_oe`,`out_ie`; then T0.
  - 1111 HLT: at T2 the next posedge enters HALT.
  - 0110 JMP: see Configuration.
  - Any other opcode is a NOP: T2 with no strobes, then T0.
- Transitions:
  - T0→T1→T2 unconditionally.
  - From T2/T3/T4, go to T0 after the opcode's last step; otherwise go to the next T-state.
  - T4 always returns to T0.
- HALT: all strobes 0, `halt` = 1, `tstate` = 0. The block stays in HALT until `rst` is asserted.
- Bus-driver rule: at most one of `pc_oe`, `ram_oe`, `ir_oe`, `a_oe`, `alu_oe` is high in any state. A bench assertion checks this.

## Timing
- Reset value while `rst` = 0: every strobe 0, `halt` = 0, `tstate` = 0. The state register is held at T0.
- On `rst` release, T0 strobes appear combinationally. The first posedge then moves the block to T1.
- Reset assertion mid-instruction clears the state immediately, independent of `clk`. No partial instruction resumes.
- One T-state equals one clock period. Strobes change only after posedge and are stable across the following negedge.
- Instruction lengths in clocks:
  - LDA 4, ADD/SUB 5, OUT 3, NOP 3, JMP 3.
  - HLT takes 3 clocks to reach HALT.
- `opcode` must be stable from the negedge inside T1 through the end of the instruction. The IR load satisfies this.

## Configuration
- Macro `CTRL_JMP_EN`.
- Defined: opcode 0110 is JMP. T2 asserts `ir_oe` and `pc_ie`, then returns to T0. `pc_step` is never high in the same state as `pc_ie`.
- Undefined: opcode 0110 decodes as a NOP. `pc_ie` is tied to 0.

## Test plan
- Reset, then 5 clocks with opcode=0000 → `tstate` 0,1,2,3,0. T0 has only `pc_oe`+`mar_ie`; T1 has only `ram_oe`+`ir_ie`+`pc_step`; T3 has `ram_oe`+`a_ie`.
- opcode=0010 → T4 reached. `alu_sub` is high only in T3 and T4. `alu_oe`+`a_ie` are high in T4, then `tstate` returns to 0.
- opcode=1110, then opcode=0101 → each takes 3 clocks. OUT T2 shows `a_oe`+`out_ie`; the NOP T2 shows all strobes 0.
- opcode=1111 → after 3 clocks `halt` = 1 and all strobes 0. The block stays there for 20 further clocks. Pulsing `rst` low returns it to T0 with `halt` = 0.
- Assert `rst` = 0 between clock edges in T3 of an ADD → outputs go to 0 without waiting for `clk`. After release, the sequence restarts at T0.
- opcode=0110: with `CTRL_JMP_EN`, T2 has `ir_oe`+`pc_ie`. Without it, T2 has no strobes and `pc_ie` is never 1. Both builds run the bus single-driver assertion over all opcodes 0000–1111.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Strobe and opcode bundle between the control sequencer and the bus-attached datapath.
// The master side is the sequencer; the slave side is the datapath that obeys the strobes.
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       pc_step;
    logic       pc_oe;
    logic       pc_ie;
    logic       mar_ie;
    logic       ram_oe;
    logic       ir_ie;
    logic       ir_oe;
    logic       a_ie;
    logic       a_oe;
    logic       b_ie;
    logic       alu_oe;
    logic       alu_sub;
    logic       out_ie;
    logic       halt;
    logic [2:0] tstate;

    modport master (
        input  opcode,
        output pc_step, pc_oe, pc_ie, mar_ie, ram_oe, ir_ie, ir_oe,
               a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie, halt, tstate
    );

    modport slave (
        output opcode,
        input  pc_step, pc_oe, pc_ie, mar_ie, ram_oe, ir_ie, ir_oe,
               a_ie, a_oe, b_ie, alu_oe, alu_sub, out_ie, halt, tstate
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore T-state sequencer for the 8-bit bus computer: fetch in T0/T1, opcode-decoded execute in T2-T4.
// Define CTRL_JMP_EN to decode opcode 0110 as JMP; otherwise it executes as a NOP.
module control_sequencer (
    input  logic                        clk,
    input  logic                        rst,
    control_sequencer_if.master         bus
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t     state;
    state_t     next_state;

    logic       pc_step;
    logic       pc_oe;
    logic       pc_ie;
    logic       mar_ie;
    logic       ram_oe;
    logic       ir_ie;
    logic       ir_oe;
    logic       a_ie;
    logic       a_oe;
    logic       b_ie;
    logic       alu_oe;
    logic       alu_sub;
    logic       out_ie;
    logic       halt;
    logic [2:0] tstate;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Outputs stay forced low while rst is held, even though the state register already reads T0.
    always_comb begin
        next_state = state;
        pc_step    = 1'b0;
        pc_oe      = 1'b0;
        pc_ie      = 1'b0;
        mar_ie     = 1'b0;
        ram_oe     = 1'b0;
        ir_ie      = 1'b0;
        ir_oe      = 1'b0;
        a_ie       = 1'b0;
        a_oe       = 1'b0;
        b_ie       = 1'b0;
        alu_oe     = 1'b0;
        alu_sub    = 1'b0;
        out_ie     = 1'b0;
        halt       = 1'b0;
        tstate     = 3'd0;

        if (rst) begin
            case (state)
                T0: begin
                    tstate     = 3'd0;
                    pc_oe      = 1'b1;
                    mar_ie     = 1'b1;
                    next_state = T1;
                end
                T1: begin
                    tstate     = 3'd1;
                    ram_oe     = 1'b1;
                    ir_ie      = 1'b1;
                    pc_step    = 1'b1;
                    next_state = T2;
                end
                T2: begin
                    tstate     = 3'd2;
                    next_state = T0;
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_oe      = 1'b1;
                            mar_ie     = 1'b1;
                            next_state = T3;
                        end
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                        end
                        OP_HLT: begin
                            next_state = HALT;
                        end
`ifdef CTRL_JMP_EN
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ie = 1'b1;
                        end
`endif
                        default: begin
                            next_state = T0;
                        end
                    endcase
                end
                T3: begin
                    tstate     = 3'd3;
                    next_state = T0;
                    case (bus.opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe     = 1'b1;
                            b_ie       = 1'b1;
                            alu_sub    = (bus.opcode == OP_SUB);
                            next_state = T4;
                        end
                        default: begin
                            next_state = T0;
                        end
                    endcase
                end
                T4: begin
                    tstate     = 3'd4;
                    next_state = T0;
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        alu_oe  = 1'b1;
                        a_ie    = 1'b1;
                        alu_sub = (bus.opcode == OP_SUB);
                    end
                end
                HALT: begin
                    halt       = 1'b1;
                    next_state = HALT;
                end
                default: begin
                    next_state = T0;
                end
            endcase
        end
    end

    assign bus.pc_step = pc_step;
    assign bus.pc_oe   = pc_oe;
    assign bus.pc_ie   = pc_ie;
    assign bus.mar_ie  = mar_ie;
    assign bus.ram_oe  = ram_oe;
    assign bus.ir_ie   = ir_ie;
    assign bus.ir_oe   = ir_oe;
    assign bus.a_ie    = a_ie;
    assign bus.a_oe    = a_oe;
    assign bus.b_ie    = b_ie;
    assign bus.alu_oe  = alu_oe;
    assign bus.alu_sub = alu_sub;
    assign bus.out_ie  = out_ie;
    assign bus.halt    = halt;
    assign bus.tstate  = tstate;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of per-T-state expectations plus halt, async reset and bus-driver sweeps.
module tb_control_sequencer;

    localparam logic [12:0] PC_STEP = 13'h1000;
    localparam logic [12:0] PC_OE   = 13'h0800;
    localparam logic [12:0] PC_IE   = 13'h0400;
    localparam logic [12:0] MAR_IE  = 13'h0200;
    localparam logic [12:0] RAM_OE  = 13'h0100;
    localparam logic [12:0] IR_IE   = 13'h0080;
    localparam logic [12:0] IR_OE   = 13'h0040;
    localparam logic [12:0] A_IE    = 13'h0020;
    localparam logic [12:0] A_OE    = 13'h0010;
    localparam logic [12:0] B_IE    = 13'h0008;
    localparam logic [12:0] ALU_OE  = 13'h0004;
    localparam logic [12:0] ALU_SUB = 13'h0002;
    localparam logic [12:0] OUT_IE  = 13'h0001;
    localparam logic [12:0] NONE    = 13'h0000;

    localparam logic [12:0] FETCH0 = PC_OE | MAR_IE;
    localparam logic [12:0] FETCH1 = RAM_OE | IR_IE | PC_STEP;
`ifdef CTRL_JMP_EN
    localparam logic [12:0] JMP_T2 = IR_OE | PC_IE;
`else
    localparam logic [12:0] JMP_T2 = NONE;
`endif

    typedef struct packed {
        logic [3:0]  opcode;
        logic [2:0]  tstate;
        logic [12:0] strobes;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] strobeVec();
        return {bus.pc_step, bus.pc_oe, bus.pc_ie, bus.mar_ie, bus.ram_oe, bus.ir_ie,
                bus.ir_oe, bus.a_ie, bus.a_oe, bus.b_ie, bus.alu_oe, bus.alu_sub, bus.out_ie};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op);
        bus.opcode = op;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    // Single bus driver plus the pc_ie rule for the current build.
    task automatic checkBus(input string label);
        int drivers;
        drivers = $countones({bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe});
        checks++;
        assert (drivers <= 1)
        else begin
            $display("[TB] FAIL %s bus_drivers: got %0d, need <= 1", label, drivers);
            errors++;
        end
        checks++;
`ifdef CTRL_JMP_EN
        assert (!(bus.pc_ie && bus.pc_step))
        else begin
            $display("[TB] FAIL %s pc_ie_with_step: got pc_ie=%b pc_step=%b, need not both", label, bus.pc_ie, bus.pc_step);
            errors++;
        end
`else
        assert (!bus.pc_ie)
        else begin
            $display("[TB] FAIL %s pc_ie_tied: got %b, need 0", label, bus.pc_ie);
            errors++;
        end
`endif
    endtask

    task automatic checkOutput(input string label, input logic [2:0] expTs,
                               input logic [12:0] expSt, input logic expHalt);
        logic [12:0] st;
        st = strobeVec();
        checks++;
        if (st !== expSt || bus.tstate !== expTs || bus.halt !== expHalt) begin
            $display("[TB] FAIL %s: got strobes=%h tstate=%0d halt=%b, need strobes=%h tstate=%0d halt=%b",
                     label, st, bus.tstate, bus.halt, expSt, expTs, expHalt);
            errors++;
        end
        checkBus(label);
    endtask

    task automatic addVec(input logic [3:0] op, input logic [2:0] ts, input logic [12:0] st);
        vecs.push_back({op, ts, st});
    endtask

    task automatic addFetch(input logic [3:0] op);
        addVec(op, 3'd0, FETCH0);
        addVec(op, 3'd1, FETCH1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        bus.opcode = 4'b0000;

        addFetch(4'b0000);
        addVec(4'b0000, 3'd2, IR_OE | MAR_IE);
        addVec(4'b0000, 3'd3, RAM_OE | A_IE);
        addFetch(4'b0001);
        addVec(4'b0001, 3'd2, IR_OE | MAR_IE);
        addVec(4'b0001, 3'd3, RAM_OE | B_IE);
        addVec(4'b0001, 3'd4, ALU_OE | A_IE);
        addFetch(4'b0010);
        addVec(4'b0010, 3'd2, IR_OE | MAR_IE);
        addVec(4'b0010, 3'd3, RAM_OE | B_IE | ALU_SUB);
        addVec(4'b0010, 3'd4, ALU_OE | A_IE | ALU_SUB);
        addFetch(4'b1110);
        addVec(4'b1110, 3'd2, A_OE | OUT_IE);
        addFetch(4'b0101);
        addVec(4'b0101, 3'd2, NONE);
        addFetch(4'b0110);
        addVec(4'b0110, 3'd2, JMP_T2);
        addVec(4'b0000, 3'd0, FETCH0);

        // Reset held across clock edges keeps every output low.
        tick();
        checkOutput("reset_held0", 3'd0, NONE, 1'b0);
        tick();
        checkOutput("reset_held1", 3'd0, NONE, 1'b0);
        rst = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].opcode);
            checkOutput($sformatf("vec%0d_op%b", i, vecs[i].opcode), vecs[i].tstate, vecs[i].strobes, 1'b0);
            tick();
        end

        // HLT parks the sequencer until reset.
        doReset();
        applyStimulus(4'b1111);
        checkOutput("hlt_t0", 3'd0, FETCH0, 1'b0);
        tick();
        checkOutput("hlt_t1", 3'd1, FETCH1, 1'b0);
        tick();
        checkOutput("hlt_t2", 3'd2, NONE, 1'b0);
        tick();
        checkOutput("hlt_enter", 3'd0, NONE, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("hlt_stay%0d", i), 3'd0, NONE, 1'b1);
        end
        rst = 1'b0;
        #1;
        checkOutput("hlt_reset_low", 3'd0, NONE, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("hlt_reset_release", 3'd0, FETCH0, 1'b0);

        // Asynchronous reset in the middle of ADD T3, away from any clock edge.
        tick();
        doReset();
        applyStimulus(4'b0001);
        tick();
        tick();
        tick();
        checkOutput("add_t3_before_reset", 3'd3, RAM_OE | B_IE, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("add_async_reset", 3'd0, NONE, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("add_restart_t0", 3'd0, FETCH0, 1'b0);
        tick();
        checkOutput("add_restart_t1", 3'd1, FETCH1, 1'b0);
        tick();
        checkOutput("add_restart_t2", 3'd2, IR_OE | MAR_IE, 1'b0);

        // Sweep every opcode for the bus single-driver and pc_ie rules.
        for (int op = 0; op < 16; op++) begin
            tick();
            doReset();
            applyStimulus(op[3:0]);
            for (int c = 0; c < 7; c++) begin
                checkBus($sformatf("sweep_op%0d_c%0d", op, c));
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
